bram_image_writer: RTL and testbench

- Write-side counterpart of the VGA frame-buffer read path.
- Accepts a byte stream of 24-bit RGB pixels (R, G, B byte order) from the serial receive path.
- Quantises each pixel to RGB111 and writes it into the frame-buffer BRAM as 00000RGB, at sequential raster addresses 0 .. H_RES*V_RES-1.
- The display path reads the same BRAM concurrently through its own port.

---
 rtl/bram_image_writer.sv | 141 ++++++++++++++
 tb/tb_bram_image_writer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_image_writer.sv
// Frame-buffer write side: assembles R,G,B bytes into RGB111 pixels and writes them to BRAM in raster order.
// Optional mid-frame stall abort is enabled by defining BRAM_WRITER_TIMEOUT_EN.
module bram_image_writer #(
  parameter int H_RES          = 640,
  parameter int V_RES          = 480,
  parameter int ADDR_W         = 19,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              error
);

  localparam int NUM_PIXELS = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_R,
    GET_G,
    GET_B,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              r_bit;
  logic              g_bit;
  logic              accept;
  logic              chan_bit;
  logic              in_get;
  logic              timeout_hit;

  assign accept   = rx_valid && rx_ready;
  assign chan_bit = (rx_data >= 8'h80);
  assign in_get   = (state == GET_R) || (state == GET_G) || (state == GET_B);

`ifdef BRAM_WRITER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_cnt;

  // Counts consecutive byte-wait cycles; leaving the GET states or accepting a byte restarts it.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!in_get || accept) begin
      stall_cnt <= '0;
    end else if (!timeout_hit) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

  assign timeout_hit = in_get && !accept && (stall_cnt >= STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((state == IDLE) && start) begin
      error <= 1'b0;
    end else if (timeout_hit) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)  next_state = GET_R;
      GET_R:   if (accept) next_state = GET_G;
      GET_G:   if (accept) next_state = GET_B;
      GET_B:   if (accept) next_state = WRITE;
      WRITE:   next_state = (addr_cnt == LAST_ADDR) ? DONE : GET_R;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (timeout_hit) next_state = IDLE;
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      r_bit       <= 1'b0;
      g_bit       <= 1'b0;
      rx_ready    <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
    end else begin
      state      <= next_state;
      rx_ready   <= (next_state == GET_R) || (next_state == GET_G) || (next_state == GET_B);
      busy       <= (next_state == GET_R) || (next_state == GET_G) || (next_state == GET_B) ||
                    (next_state == WRITE);
      bram_we    <= (next_state == WRITE);
      frame_done <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt    <= '0;
            pixel_count <= '0;
          end
        end
        GET_R: if (accept) r_bit <= chan_bit;
        GET_G: if (accept) g_bit <= chan_bit;
        GET_B: begin
          if (accept) begin
            bram_addr   <= addr_cnt;
            bram_wdata  <= {5'b00000, r_bit, g_bit, chan_bit};
            pixel_count <= pixel_count + ADDR_W'(1);
          end
        end
        WRITE: begin
          if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_image_writer.sv
// Directed testbench for bram_image_writer on a reduced 8x3 frame so a full frame runs quickly.
// Define BRAM_WRITER_TIMEOUT_EN to exercise the stall abort with TIMEOUT_CYCLES=50.
module tb_bram_image_writer;

  localparam int H    = 8;
  localparam int V    = 3;
  localparam int AW   = 5;
  localparam int NPIX = H * V;
  localparam int TO   = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_wdata;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] pixel_count;
  logic          error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_we_cyc = -1;
  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [7:0]    exp_data[NPIX];

  bram_image_writer #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_25mhz(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Passive monitor: records every write, frame_done pulse and byte handshake.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wr_addr_q.push_back(bram_addr);
      wr_data_q.push_back(bram_wdata);
      last_we_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_valid && rx_ready === 1'b1) accept_cnt++;
  end

  function automatic logic [7:0] pat(input int i, input int ch);
    return 8'((i * 53 + ch * 101 + 7) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
    ok = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (rx_ready === 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_checked(input logic [7:0] b, input int max_gap);
    bit ok;
    repeat ($urandom_range(0, max_gap)) tick();
    send_byte(b, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL byte_accept_timeout got=0 exp=1 byte=%02h", b);
    end
  endtask

  task automatic send_pixel(input int idx, input int max_gap);
    logic [7:0] r, g, b;
    r = pat(idx, 0);
    g = pat(idx, 1);
    b = pat(idx, 2);
    exp_data[idx] = {5'b00000, r[7], g[7], b[7]};
    send_checked(r, max_gap);
    send_checked(g, max_gap);
    send_checked(b, max_gap);
  endtask

  task automatic clear_monitor();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_we_cyc = -1;
  endtask

  task automatic test_reset();
    int rdy_hi;
    rdy_hi = 0;
    rx_valid = 1'b1;
    rx_data = 8'hFF;
    repeat (3) tick();
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_rx_ready got=%0b exp=0", rx_ready); end
    checks++; if (bram_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_bram_we got=%0b exp=0", bram_we); end
    checks++; if (bram_addr !== '0) begin failures++; $display("[TB] FAIL rst_bram_addr got=%0h exp=0", bram_addr); end
    checks++; if (bram_wdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_bram_wdata got=%0h exp=0", bram_wdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_frame_done got=%0b exp=0", frame_done); end
    checks++; if (pixel_count !== '0) begin failures++; $display("[TB] FAIL rst_pixel_count got=%0d exp=0", pixel_count); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL rst_error got=%0b exp=0", error); end
    reset = 1'b0;
    clear_monitor();
    accept_cnt = 0;
    repeat (100) begin
      tick();
      if (rx_ready !== 1'b0) rdy_hi++;
    end
    rx_valid = 1'b0;
    checks++; if (rdy_hi != 0) begin failures++; $display("[TB] FAIL idle_rx_ready_cycles got=%0d exp=0", rdy_hi); end
    checks++; if (accept_cnt != 0) begin failures++; $display("[TB] FAIL idle_accepts got=%0d exp=0", accept_cnt); end
    checks++; if (wr_addr_q.size() != 0) begin failures++; $display("[TB] FAIL idle_writes got=%0d exp=0", wr_addr_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_single_pixel();
    clear_monitor();
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL start_busy got=%0b exp=1", busy); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("[TB] FAIL start_rx_ready got=%0b exp=1", rx_ready); end
    send_checked(8'hFF, 0);
    send_checked(8'h00, 0);
    send_checked(8'h80, 0);
    exp_data[0] = 8'h05;
    checks++; if (bram_we !== 1'b1) begin failures++; $display("[TB] FAIL single_we got=%0b exp=1", bram_we); end
    checks++; if (bram_addr !== 5'd0) begin failures++; $display("[TB] FAIL single_addr got=%0d exp=0", bram_addr); end
    checks++; if (bram_wdata !== 8'h05) begin failures++; $display("[TB] FAIL single_wdata got=%02h exp=05", bram_wdata); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL write_rx_ready got=%0b exp=0", rx_ready); end
    tick();
    checks++; if (bram_we !== 1'b0) begin failures++; $display("[TB] FAIL single_we_pulse got=%0b exp=0", bram_we); end
    checks++; if (bram_wdata !== 8'h05) begin failures++; $display("[TB] FAIL single_wdata_hold got=%02h exp=05", bram_wdata); end
    checks++; if (pixel_count !== 5'd1) begin failures++; $display("[TB] FAIL single_pixel_count got=%0d exp=1", pixel_count); end
  endtask

  task automatic test_threshold();
    send_checked(8'h7F, 1);
    send_checked(8'h80, 1);
    send_checked(8'h7F, 1);
    exp_data[1] = 8'h02;
    checks++; if (bram_we !== 1'b1) begin failures++; $display("[TB] FAIL thr_we got=%0b exp=1", bram_we); end
    checks++; if (bram_addr !== 5'd1) begin failures++; $display("[TB] FAIL thr_addr got=%0d exp=1", bram_addr); end
    checks++; if (bram_wdata !== 8'h02) begin failures++; $display("[TB] FAIL thr_wdata got=%02h exp=02", bram_wdata); end
    tick();
    checks++; if (pixel_count !== 5'd2) begin failures++; $display("[TB] FAIL thr_pixel_count got=%0d exp=2", pixel_count); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] r, g, b;
    for (int i = 2; i < 10; i++) send_pixel(i, 2);
    r = pat(10, 0);
    g = pat(10, 1);
    b = pat(10, 2);
    exp_data[10] = {5'b00000, r[7], g[7], b[7]};
    send_checked(r, 0);
    pulse_start();
    send_checked(g, 0);
    send_checked(b, 0);
    tick();
    checks++; if (pixel_count !== 5'd11) begin failures++; $display("[TB] FAIL midstart_count got=%0d exp=11", pixel_count); end
    checks++; if (wr_addr_q[$] !== 5'd10) begin failures++; $display("[TB] FAIL midstart_addr got=%0d exp=10", wr_addr_q[$]); end
    send_pixel(11, 1);
    send_pixel(12, 1);
    tick();
    checks++; if (wr_addr_q[$] !== 5'd12) begin failures++; $display("[TB] FAIL midstart_addr12 got=%0d exp=12", wr_addr_q[$]); end
    checks++; if (pixel_count !== 5'd13) begin failures++; $display("[TB] FAIL midstart_count13 got=%0d exp=13", pixel_count); end
  endtask

  task automatic test_full_frame();
    bit ok;
    int acc_before;
    for (int i = 13; i < NPIX; i++) send_pixel(i, 3);
    pulse_start();
    repeat (5) tick();
    checks++; if (wr_addr_q.size() != NPIX) begin failures++; $display("[TB] FAIL frame_writes got=%0d exp=%0d", wr_addr_q.size(), NPIX); end
    for (int i = 0; i < NPIX && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== AW'(i)) begin failures++; $display("[TB] FAIL frame_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], i); end
      checks++; if (wr_data_q[i] !== exp_data[i]) begin failures++; $display("[TB] FAIL frame_data[%0d] got=%02h exp=%02h", i, wr_data_q[i], exp_data[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL frame_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_cyc != last_we_cyc + 1) begin failures++; $display("[TB] FAIL frame_done_timing got=%0d exp=%0d", done_cyc, last_we_cyc + 1); end
    checks++; if (pixel_count !== AW'(NPIX)) begin failures++; $display("[TB] FAIL frame_pixel_count got=%0d exp=%0d", pixel_count, NPIX); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL frame_busy got=%0b exp=0", busy); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL late_start_rx_ready got=%0b exp=0", rx_ready); end
    acc_before = accept_cnt;
    send_byte(8'hAA, 20, ok);
    checks++; if (ok || accept_cnt != acc_before) begin failures++; $display("[TB] FAIL extra_byte got=%0d exp=0", accept_cnt - acc_before); end
    checks++; if (wr_addr_q.size() != NPIX) begin failures++; $display("[TB] FAIL extra_writes got=%0d exp=%0d", wr_addr_q.size(), NPIX); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_monitor();
    pulse_start();
    for (int i = 0; i < 5; i++) send_pixel(i, 1);
    send_checked(pat(5, 0), 0);
    send_checked(pat(5, 1), 0);
    reset = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("[TB] FAIL midrst_rx_ready got=%0b exp=0", rx_ready); end
    checks++; if (pixel_count !== '0) begin failures++; $display("[TB] FAIL midrst_pixel_count got=%0d exp=0", pixel_count); end
    repeat (2) tick();
    reset = 1'b0;
    send_byte(pat(5, 2), 10, ok);
    repeat (5) tick();
    checks++; if (ok) begin failures++; $display("[TB] FAIL midrst_accept got=1 exp=0"); end
    checks++; if (wr_addr_q.size() != 5) begin failures++; $display("[TB] FAIL midrst_writes got=%0d exp=5", wr_addr_q.size()); end
    checks++; if (wr_addr_q.size() > 0 && wr_addr_q[$] !== 5'd4) begin failures++; $display("[TB] FAIL midrst_last_addr got=%0d exp=4", wr_addr_q[$]); end
    checks++; if (done_cnt != 0) begin failures++; $display("[TB] FAIL midrst_done got=%0d exp=0", done_cnt); end
  endtask

`ifdef BRAM_WRITER_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    clear_monitor();
    pulse_start();
    for (int i = 0; i < 3; i++) send_pixel(i, 1);
    send_checked(pat(3, 0), 0);
    repeat (40) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL to_early_busy got=%0b exp=1", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL to_early_error got=%0b exp=0", error); end
    waited = 0;
    while (busy === 1'b1 && waited < 30) begin
      tick();
      waited++;
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL to_abort got=busy exp=idle"); end
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL to_error got=%0b exp=1", error); end
    checks++; if (pixel_count !== 5'd3) begin failures++; $display("[TB] FAIL to_pixel_count got=%0d exp=3", pixel_count); end
    checks++; if (done_cnt != 0) begin failures++; $display("[TB] FAIL to_done got=%0d exp=0", done_cnt); end
    checks++; if (wr_addr_q.size() != 3) begin failures++; $display("[TB] FAIL to_writes got=%0d exp=3", wr_addr_q.size()); end
    repeat (5) tick();
    checks++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL to_sticky got=%0b exp=1", error); end
    pulse_start();
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL to_clear got=%0b exp=0", error); end
  endtask
`else
  task automatic test_no_timeout();
    clear_monitor();
    pulse_start();
    send_checked(8'hC0, 0);
    repeat (100) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL stall_busy got=%0b exp=1", busy); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_rx_ready got=%0b exp=1", rx_ready); end
    checks++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL stall_error got=%0b exp=0", error); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_threshold();
    test_start_ignored();
    test_full_frame();
    test_reset_mid_frame();
`ifdef BRAM_WRITER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
